// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - decode-stage BEQ resolver: waits out operand hazards, then releases the stall and redirects fetch.
// Optional saturating branch/taken statistics counters are built when BRANCH_STATS_EN is defined.
module branch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic        hazard_i,
  input  logic [31:0] rd1_i,
  input  logic [31:0] rd2_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] pc_plus_4_i,
  output logic        resume_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic        timeout_o,
  output logic [15:0] branch_count_o,
  output logic [15:0] taken_count_o
);

  typedef enum logic [1:0] {IDLE, WAIT_OPS, RESOLVE, RELEASE} state_t;

  state_t      state, state_nxt;
  logic [31:0] rd1_q, rd2_q, pc_q, target_q;
  logic [29:0] imm_q;
  logic [3:0]  wait_q;
  logic        taken_q, tmo_q, released_q;
  logic        capture, recapture, inc_wait, set_tmo, resolve;
  logic        in_release;

  // The branch offset is in words, so its top two bits fall off the <<2.
  logic unused_imm_bits;
  assign unused_imm_bits = &{1'b0, imm_i[31:30]};

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    recapture = 1'b0;
    inc_wait  = 1'b0;
    set_tmo   = 1'b0;
    resolve   = 1'b0;
    case (state)
      IDLE: begin
        // released_q masks the stall decode is still dropping after RELEASE.
        if (stall_i && branch_i && !released_q) begin
          capture   = 1'b1;
          state_nxt = WAIT_OPS;
        end
      end
      WAIT_OPS: begin
        if (!stall_i) begin
          state_nxt = IDLE;
        end else begin
          recapture = 1'b1;
          if (!hazard_i) begin
            state_nxt = RESOLVE;
          end else if (wait_q == 4'hF) begin
            set_tmo   = 1'b1;
            state_nxt = RESOLVE;
          end else begin
            inc_wait = 1'b1;
          end
        end
      end
      RESOLVE: begin
        if (!stall_i) begin
          state_nxt = IDLE;
        end else begin
          resolve   = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      target_q   <= '0;
      wait_q     <= '0;
      taken_q    <= 1'b0;
      tmo_q      <= 1'b0;
      released_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      released_q <= (state == RELEASE);
      if (capture) begin
        rd1_q  <= rd1_i;
        rd2_q  <= rd2_i;
        imm_q  <= imm_i[29:0];
        pc_q   <= pc_plus_4_i;
        wait_q <= '0;
        tmo_q  <= 1'b0;
      end
      if (recapture) begin
        rd1_q <= rd1_i;
        rd2_q <= rd2_i;
      end
      if (inc_wait) wait_q <= wait_q + 4'd1;
      if (set_tmo)  tmo_q  <= 1'b1;
      if (resolve) begin
        taken_q  <= (rd1_q == rd2_q);
        target_q <= pc_q + {imm_q, 2'b00};
      end
    end
  end

  assign in_release       = (state == RELEASE);
  assign resume_o         = in_release;
  assign redirect_valid_o = in_release && taken_q;
  assign flush_o          = in_release && taken_q;
  assign redirect_pc_o    = (in_release && taken_q) ? target_q : 32'd0;
  assign timeout_o        = in_release && tmo_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] br_cnt_q, tk_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else if (in_release) begin
      if (br_cnt_q != 16'hFFFF)            br_cnt_q <= br_cnt_q + 16'd1;
      if (taken_q && tk_cnt_q != 16'hFFFF) tk_cnt_q <= tk_cnt_q + 16'd1;
    end
  end

  assign branch_count_o = br_cnt_q;
  assign taken_count_o  = tk_cnt_q;
`else
  assign branch_count_o = 16'd0;
  assign taken_count_o  = 16'd0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - randomized self-checking bench for branch_unit against a latency/target model.
module tb_branch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0, branch_i = 1'b0, hazard_i = 1'b0;
  logic [31:0] rd1_i = '0, rd2_i = '0, imm_i = '0, pc_plus_4_i = '0;
  logic        resume_o, redirect_valid_o, flush_o, timeout_o;
  logic [31:0] redirect_pc_o;
  logic [15:0] branch_count_o, taken_count_o;

  int tests = 0;
  int fails = 0;
  int n_branches = 0;
  int n_taken = 0;

  branch_unit dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_i(branch_i), .hazard_i(hazard_i),
    .rd1_i(rd1_i), .rd2_i(rd2_i), .imm_i(imm_i), .pc_plus_4_i(pc_plus_4_i),
    .resume_o(resume_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .flush_o(flush_o), .timeout_o(timeout_o),
    .branch_count_o(branch_count_o), .taken_count_o(taken_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_count(input int n);
`ifdef BRANCH_STATS_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return (n >= 0) ? 16'd0 : 16'd0;
`endif
  endfunction

  // One branch end to end. h = number of hazard cycles after the trigger.
  task automatic drive_branch(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic [31:0] pc, input int h,
                              input bit hold_stall, input bit release_rst);
    int lat, last_wait;
    bit tk, tmo;
    logic [31:0] tgt, want_pc;
    logic [3:0] got, want;
    lat       = 3 + ((h > 15) ? 15 : h);
    tmo       = (h > 15);
    last_wait = lat - 2;
    tk        = (a == b);
    tgt       = pc + imm * 4;
    @(negedge clk);
    if (release_rst) rst = 1'b1;
    stall_i = 1'b1; branch_i = 1'b1; hazard_i = 1'b0;
    rd1_i = $urandom; rd2_i = $urandom; imm_i = imm; pc_plus_4_i = pc;
    for (int n = 1; n <= lat + 5; n++) begin
      @(negedge clk);
      want    = (n == lat) ? {1'b1, tk, tk, tmo} : 4'b0000;
      want_pc = (n == lat && tk) ? tgt : 32'd0;
      got     = {resume_o, redirect_valid_o, flush_o, timeout_o};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL %s pulses T+%0d: got resume/redir/flush/tmo=%b want %b", name, n, got, want);
      end
      tests++;
      if (redirect_pc_o !== want_pc) begin
        fails++;
        $display("FAIL %s redirect_pc T+%0d: got %h want %h", name, n, redirect_pc_o, want_pc);
      end
      hazard_i    = (n - 1 < h);
      imm_i       = $urandom;
      pc_plus_4_i = $urandom;
      if (n == last_wait) begin
        rd1_i = a; rd2_i = b;
      end else begin
        rd1_i = $urandom; rd2_i = $urandom;
      end
      if (n <= lat) begin
        stall_i = 1'b1; branch_i = 1'($urandom);
      end else if (n == lat + 1) begin
        stall_i = hold_stall; branch_i = hold_stall;
      end else if (n <= lat + 4) begin
        stall_i = hold_stall; branch_i = 1'b0;
      end else begin
        stall_i = 1'b0; branch_i = 1'b0;
      end
    end
    n_branches++;
    if (tk) n_taken++;
    tests++;
    if (branch_count_o !== exp_count(n_branches) || taken_count_o !== exp_count(n_taken)) begin
      fails++;
      $display("FAIL %s counts: got %0d/%0d want %0d/%0d", name, branch_count_o, taken_count_o,
               exp_count(n_branches), exp_count(n_taken));
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({resume_o, redirect_valid_o, flush_o, timeout_o, redirect_pc_o, branch_count_o, taken_count_o} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %b %h %h %h want all zero",
               {resume_o, redirect_valid_o, flush_o, timeout_o}, redirect_pc_o, branch_count_o, taken_count_o);
    end
    stall_i = 1'b1; branch_i = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({resume_o, redirect_valid_o, flush_o, timeout_o} !== 4'b0) begin
      fails++;
      $display("FAIL reset_hold: got %b want 0000", {resume_o, redirect_valid_o, flush_o, timeout_o});
    end
    drive_branch("first_trigger_taken", 32'd5, 32'd5, 32'd3, 32'h100, 0, 1'b0, 1'b1);
  endtask

  task automatic test_directed();
    drive_branch("not_taken", 32'd5, 32'd6, 32'd3, 32'h100, 0, 1'b0, 1'b0);
    drive_branch("hazard4_taken", 32'd5, 32'd5, 32'd8, 32'h2000, 4, 1'b0, 1'b0);
    drive_branch("timeout_wrap", 32'd9, 32'd9, 32'hFFFFFFFF, 32'h0, 20, 1'b0, 1'b0);
    drive_branch("hazard15_no_tmo", 32'd1, 32'd2, 32'd1, 32'h40, 15, 1'b0, 1'b0);
  endtask

  task automatic test_stats();
    tests++;
    if (branch_count_o !== exp_count(5) || taken_count_o !== exp_count(3)) begin
      fails++;
      $display("FAIL stats_3taken_2not: got %0d/%0d want %0d/%0d",
               branch_count_o, taken_count_o, exp_count(5), exp_count(3));
    end
  endtask

  task automatic test_abort(input string name, input int h, input int n_abort);
    logic [3:0] got;
    @(negedge clk);
    stall_i = 1'b1; branch_i = 1'b1; hazard_i = 1'b0; rd1_i = 32'd4; rd2_i = 32'd4;
    for (int n = 1; n <= n_abort + 20; n++) begin
      @(negedge clk);
      got = {resume_o, redirect_valid_o, flush_o, timeout_o};
      tests++;
      if (got !== 4'b0) begin
        fails++;
        $display("FAIL %s pulses T+%0d: got %b want 0000", name, n, got);
      end
      branch_i = 1'b0;
      hazard_i = (n - 1 < h);
      stall_i  = (n < n_abort);
    end
    tests++;
    if (branch_count_o !== exp_count(n_branches) || taken_count_o !== exp_count(n_taken)) begin
      fails++;
      $display("FAIL %s counts: got %0d/%0d want %0d/%0d", name, branch_count_o, taken_count_o,
               exp_count(n_branches), exp_count(n_taken));
    end
  endtask

  task automatic test_mid_reset(input string name, input int rst_at);
    logic [3:0] got;
    @(negedge clk);
    stall_i = 1'b1; branch_i = 1'b1; hazard_i = 1'b0;
    rd1_i = 32'd7; rd2_i = 32'd7; imm_i = 32'd1; pc_plus_4_i = 32'h40;
    for (int n = 1; n <= rst_at; n++) begin
      @(negedge clk);
      branch_i = 1'b0;
    end
    rst = 1'b0; stall_i = 1'b0;
    #1;
    tests++;
    if ({resume_o, redirect_valid_o, flush_o, timeout_o, redirect_pc_o, branch_count_o, taken_count_o} !== '0) begin
      fails++;
      $display("FAIL %s immediate: got %b %h %h %h want all zero", name,
               {resume_o, redirect_valid_o, flush_o, timeout_o}, redirect_pc_o, branch_count_o, taken_count_o);
    end
    n_branches = 0; n_taken = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1; stall_i = 1'b1; branch_i = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      got = {resume_o, redirect_valid_o, flush_o, timeout_o};
      tests++;
      if (got !== 4'b0) begin
        fails++;
        $display("FAIL %s after_release cycle %0d: got %b want 0000", name, n, got);
      end
    end
    stall_i = 1'b0;
  endtask

  task automatic test_stale_stall();
    drive_branch("stale_stall_taken", 32'd11, 32'd11, 32'd2, 32'h80, 0, 1'b1, 1'b0);
    drive_branch("stale_stall_hazard", 32'd3, 32'd4, 32'd2, 32'h80, 2, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    int h;
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 1) == 1) ? a : $urandom;
      h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 18) : $urandom_range(0, 3);
      drive_branch($sformatf("random_%0d", i), a, b, $urandom, $urandom, h, 1'($urandom), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    drive_branch("b2b_0", 32'd1, 32'd1, 32'd4, 32'h1000, 0, 1'b0, 1'b0);
    drive_branch("b2b_1", 32'd1, 32'd0, 32'd4, 32'h1000, 1, 1'b0, 1'b0);
    drive_branch("b2b_2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stats();
    test_abort("abort_wait_ops", 4, 2);
    test_abort("abort_resolve", 0, 2);
    test_stale_stall();
    test_random();
    test_mid_reset("reset_in_resolve", 2);
    test_mid_reset("reset_in_release", 3);
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: port clk is the single clock and port rst is the asynchronous active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low (0 = reset).
REQ-004 stall_i  input  1  decode-stage stall request; held high until resume observed.
REQ-005 branch_i  input  1  decode-stage branch flag (BEQ decoded).
REQ-006 hazard_i  input  1  operand writer still in flight; operands not yet final.
REQ-007 rd1_i, rd2_i  input  32 each  branch compare operands (forwarded values).
REQ-008 imm_i  input  32  sign-extended branch offset, in words.
REQ-009 pc_plus_4_i  input  32  address following the branch.
REQ-010 resume_o  output  1  one-cycle pulse releasing the decode stall.
REQ-011 redirect_valid_o  output  1  one-cycle pulse; fetch loads redirect_pc_o.
REQ-012 redirect_pc_o  output  32  taken-branch target.
REQ-013 flush_o  output  1  one-cycle pulse; kills wrong-path instruction.
REQ-014 timeout_o  output  1  one-cycle pulse; branch resolved after hazard wait expired.
REQ-015 branch_count_o, taken_count_o  output  16 each  statistics counters.

Function
REQ-016 States: IDLE, WAIT_OPS, RESOLVE, RELEASE; encoding free.
REQ-017 IDLE: stall_i=1 and branch_i=1 at edge -> capture rd1_i, rd2_i, imm_i, pc_plus_4_i; go WAIT_OPS; clear wait counter.
REQ-018 IDLE with stall_i=1, branch_i=0 -> stay IDLE, no outputs.
REQ-019 WAIT_OPS, hazard_i=1: recapture rd1_i/rd2_i every cycle; increment 4-bit wait counter; stay.
REQ-020 WAIT_OPS, hazard_i=0 -> recapture rd1_i/rd2_i; go RESOLVE.
REQ-021 WAIT_OPS, wait counter = 15 with hazard_i=1 -> go RESOLVE; set timeout flag for RELEASE.
REQ-022 WAIT_OPS or RESOLVE with stall_i=0 -> abort to IDLE; no resume/redirect/flush/timeout/count.
REQ-023 RESOLVE: taken = (rd1 == rd2) on captured operands; target = pc_plus_4 + {imm[29:0],2'b00}, modulo 2^32 (wraps, no overflow flag); register both; go RELEASE.
REQ-024 RELEASE: resume_o=1; redirect_valid_o=flush_o=taken; redirect_pc_o=target if taken else 0; timeout_o=timeout flag; next IDLE unconditionally.
REQ-025 All pulse outputs SHALL be high for exactly one cycle and only in RELEASE.
REQ-026 Latency without hazard: trigger edge in cycle T -> resume_o high in cycle T+3.
REQ-027 Decode drops stall at the RELEASE edge; IDLE SHALL not re-trigger on stale stall_i in the cycle after RELEASE.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, all outputs 0, captured registers 0, wait counter 0, statistics counters 0, regardless of clk.
REQ-029 Reset asserted mid-operation SHALL discard the in-flight branch; no resume pulse after release.
REQ-030 First trigger accepted on the first rising edge with rst=1.

Configuration
REQ-031 Macro BRANCH_STATS_EN defined: branch_count_o increments on each RELEASE, taken_count_o on each taken RELEASE; both saturate at 16'hFFFF.
REQ-032 BRANCH_STATS_EN undefined: counters not built; branch_count_o and taken_count_o tied 0; ports remain.

Verification
REQ-033 rd1=rd2=5, imm=3, pc_plus_4=0x100, hazard=0 -> T+3: resume=1, redirect_valid=1, flush=1, redirect_pc=0x10C.
REQ-034 rd1=5, rd2=6, hazard=0 -> T+3: resume=1, redirect_valid=0, flush=0, redirect_pc=0.
REQ-035 hazard=1 for 4 cycles, rd2 changing 6 to 5 on last hazard cycle, rd1=5 -> resume at T+7, taken.
REQ-036 hazard held high -> resume at T+18 with timeout_o=1; imm=-1, pc_plus_4=0x0 -> redirect_pc=0xFFFFFFFC.
REQ-037 rst=0 in RESOLVE -> outputs 0 at once; no resume; stall_i=0 in WAIT_OPS -> IDLE, no pulses.
REQ-038 BRANCH_STATS_EN defined, 3 taken plus 2 not-taken branches -> branch_count_o=5, taken_count_o=3; undefined -> both 0.
